// File: rtl/mem_backing_responder_if.sv
// Memory request/response bundle between a direct-mapped cache FSM and its backing store.
// Latency: none (wires only); the responder defines request-to-ready timing.
// Backpressure: the cache holds mem_req_valid until it observes the mem_data_ready pulse.
interface mem_backing_responder_if #(
  parameter int LINE_W = 128
);
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_rw;
  logic              mem_req_valid;
  logic [LINE_W-1:0] mem_data_data;
  logic              mem_data_ready;

  // Cache side: issues requests, consumes responses.
  modport master (
    output mem_req_addr,
    output mem_req_data,
    output mem_req_rw,
    output mem_req_valid,
    input  mem_data_data,
    input  mem_data_ready
  );

  // Memory side: consumes requests, issues responses.
  modport slave (
    input  mem_req_addr,
    input  mem_req_data,
    input  mem_req_rw,
    input  mem_req_valid,
    output mem_data_data,
    output mem_data_ready
  );
endinterface

// File: rtl/mem_backing_responder.sv
// Line-granular backing memory answering a cache's read/write-line requests.
// Latency: mem_data_ready pulses LATENCY edges after acceptance; one request per LATENCY+2 cycles.
// Backpressure: no ready input; requests are only accepted in IDLE/COOL, a held valid simply waits.
module mem_backing_responder #(
  parameter int INDEX_W = 5,
  parameter int LINE_W  = 128,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    HRESETn,
  mem_backing_responder_if.slave  bus,
  output logic                    busy,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int DEPTH = 2 ** INDEX_W;
  // Counter preload; the counter then needs LATENCY-1 decrements plus one final edge.
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_COOL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic [LINE_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_rdy_q, rsp_rdy_d;
  logic [15:0]         rd_count_q, rd_count_d;
  logic [15:0]         wr_count_q, wr_count_d;

  // Storage is deliberately outside the reset domain so contents survive HRESETn.
  logic [LINE_W-1:0]   mem_q [DEPTH];
  logic                mem_we;

  // Upper address bits alias onto the same line and are intentionally dropped.
  logic                addr_unused;
  assign addr_unused = ^bus.mem_req_addr[31:INDEX_W];

  // Next-state, request capture, response generation and commit strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    rsp_data_d = rsp_data_q;
    rsp_rdy_d  = 1'b0;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;

    unique case (state_q)
      // COOL behaves like IDLE for acceptance: the stale valid from the
      // just-answered request was already swallowed on the RESP->COOL edge.
      ST_IDLE, ST_COOL: begin
        if (bus.mem_req_valid) begin
          idx_d   = bus.mem_req_addr[INDEX_W-1:0];
          wdata_d = bus.mem_req_data;
          rw_d    = bus.mem_req_rw;
          cnt_d   = LAT_M1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Latched request only. With LATENCY=1 this state lasts a single
      // cycle (counter already 0), so the response lands on E0+1.
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d   = ST_RESP;
          rsp_rdy_d = 1'b1;
          if (rw_q) begin
            mem_we     = 1'b1;
            rsp_data_d = wdata_q;
            wr_count_d = wr_count_q + 16'd1;
          end else begin
            rsp_data_d = mem_q[idx_q];
            rd_count_d = rd_count_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Ready is up for exactly this cycle; valid seen on the exit edge is
      // the cache's stale request and is ignored.
      ST_RESP: begin
        state_d = ST_COOL;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; async reset abandons any in-flight request.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_rdy_q  <= 1'b0;
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      rsp_data_q <= rsp_data_d;
      rsp_rdy_q  <= rsp_rdy_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Line array write port; commits on the same edge that raises ready.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.mem_data_data  = rsp_data_q;
  assign bus.mem_data_ready = rsp_rdy_q;
  assign busy               = (state_q != ST_IDLE);
  assign rd_count           = rd_count_q;
  assign wr_count           = wr_count_q;

endmodule

// File: tb/tb_mem_backing_responder.sv
// Bench for mem_backing_responder: one LATENCY=4 and one LATENCY=1 instance.
// Expected data/counts come from a line-array and counter model kept here.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_mem_backing_responder;
  localparam int LW = 128;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic HRESETn;
  always #5 clk = ~clk;

  mem_backing_responder_if #(.LINE_W(LW)) bus4 ();
  mem_backing_responder_if #(.LINE_W(LW)) bus1 ();
  logic        busy4, busy1;
  logic [15:0] rdc4, wrc4, rdc1, wrc1;

  mem_backing_responder #(.INDEX_W(IW), .LINE_W(LW), .LATENCY(4)) dut4 (
    .clk(clk), .HRESETn(HRESETn), .bus(bus4),
    .busy(busy4), .rd_count(rdc4), .wr_count(wrc4)
  );
  mem_backing_responder #(.INDEX_W(IW), .LINE_W(LW), .LATENCY(1)) dut1 (
    .clk(clk), .HRESETn(HRESETn), .bus(bus1),
    .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
  );

  // Reference model: plain line arrays (zero at time zero, untouched by reset) and counters.
  logic [LW-1:0] mem4 [32];
  logic [LW-1:0] mem1 [32];
  logic [15:0]   m_rd4, m_wr4, m_rd1, m_wr1;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  typedef struct {
    int          lat;
    logic [LW-1:0] data;
    bit          one_wide;
    bit          busy_e0;
    bit          busy_cool;
    bit          idle_after;
  } obs_t;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic rdy_of(input bit sel1);
    return sel1 ? bus1.mem_data_ready : bus4.mem_data_ready;
  endfunction

  function automatic logic busy_of(input bit sel1);
    return sel1 ? busy1 : busy4;
  endfunction

  function automatic logic [LW-1:0] data_of(input bit sel1);
    return sel1 ? bus1.mem_data_data : bus4.mem_data_data;
  endfunction

  task automatic drive(input bit sel1, input logic [31:0] addr, input logic [LW-1:0] wd,
                       input bit rw, input bit v);
    if (sel1) begin
      bus1.mem_req_addr = addr; bus1.mem_req_data = wd;
      bus1.mem_req_rw = rw; bus1.mem_req_valid = v;
    end else begin
      bus4.mem_req_addr = addr; bus4.mem_req_data = wd;
      bus4.mem_req_rw = rw; bus4.mem_req_valid = v;
    end
  endtask

  // Model of one completed transaction: returns the line the response must carry.
  function automatic logic [LW-1:0] model_step(input bit sel1, input logic [31:0] addr,
                                               input logic [LW-1:0] wd, input bit rw);
    int i;
    i = int'(addr % 32);
    if (sel1) begin
      if (rw) begin mem1[i] = wd; m_wr1++; return wd; end
      m_rd1++; return mem1[i];
    end
    if (rw) begin mem4[i] = wd; m_wr4++; return wd; end
    m_rd4++; return mem4[i];
  endfunction

  // One full cache-style handshake on an idle instance; collects observations only.
  task automatic xact(input bit sel1, input logic [31:0] addr, input logic [LW-1:0] wd,
                      input bit rw, output obs_t o);
    o.lat = -1; o.data = '0; o.one_wide = 0; o.busy_e0 = 0; o.busy_cool = 0; o.idle_after = 0;
    @(negedge clk);
    drive(sel1, addr, wd, rw, 1'b1);
    @(posedge clk); #1;                        // E0
    o.busy_e0 = busy_of(sel1);
    drive(sel1, $urandom, rand_line(), ~rw, 1'b1);   // inputs need not stay stable
    for (int n = 1; n <= 20 && o.lat < 0; n++) begin
      @(posedge clk); #1;
      if (rdy_of(sel1)) begin
        o.lat  = n;
        o.data = data_of(sel1);
      end
    end
    @(negedge clk);
    drive(sel1, 32'h0, '0, 1'b0, 1'b0);
    if (o.lat >= 0) begin
      @(posedge clk); #1;
      o.one_wide  = !rdy_of(sel1);
      o.busy_cool = busy_of(sel1);
      @(posedge clk); #1;
      o.idle_after = !busy_of(sel1);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++; if (bus4.mem_data_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", bus4.mem_data_ready); else pass_cnt++;
    tot_cnt++; if (bus4.mem_data_data !== '0) $display("FAIL rst_data: got %h want 0", bus4.mem_data_data); else pass_cnt++;
    tot_cnt++; if (busy4 !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy4); else pass_cnt++;
    tot_cnt++; if ({rdc4, wrc4} !== 32'h0) $display("FAIL rst_counts: got %h want 0", {rdc4, wrc4}); else pass_cnt++;
    tot_cnt++; if ({bus1.mem_data_ready, busy1, rdc1, wrc1} !== 34'h0) $display("FAIL rst_lat1: got %h want 0", {bus1.mem_data_ready, busy1, rdc1, wrc1}); else pass_cnt++;
    @(negedge clk);
    HRESETn = 1'b1;
  endtask

  task automatic test_write_read();
    obs_t o;
    logic [LW-1:0] d, e;
    d = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    xact(1'b0, 32'd5, d, 1'b1, o);
    e = model_step(1'b0, 32'd5, d, 1'b1);
    tot_cnt++; if (o.lat !== 4) $display("FAIL wr_latency: got %0d want 4", o.lat); else pass_cnt++;
    tot_cnt++; if (o.data !== e) $display("FAIL wr_echo: got %h want %h", o.data, e); else pass_cnt++;
    tot_cnt++; if (!o.one_wide) $display("FAIL wr_pulse_width: ready still high next cycle, want low"); else pass_cnt++;
    tot_cnt++; if (!o.busy_e0) $display("FAIL wr_busy_e0: busy low after E0, want high"); else pass_cnt++;
    tot_cnt++; if (!o.busy_cool) $display("FAIL wr_busy_cool: busy low after E0+5, want high"); else pass_cnt++;
    tot_cnt++; if (!o.idle_after) $display("FAIL wr_busy_fall: busy high after E0+6, want low"); else pass_cnt++;
    xact(1'b0, 32'd5, rand_line(), 1'b0, o);
    e = model_step(1'b0, 32'd5, '0, 1'b0);
    tot_cnt++; if (o.lat !== 4) $display("FAIL rd_latency: got %0d want 4", o.lat); else pass_cnt++;
    tot_cnt++; if (o.data !== e) $display("FAIL rd_after_wr: got %h want %h", o.data, e); else pass_cnt++;
    tot_cnt++; if (wrc4 !== 16'd1 || rdc4 !== 16'd1) $display("FAIL wr_rd_counts: got wr=%0d rd=%0d want 1/1", wrc4, rdc4); else pass_cnt++;
  endtask

  task automatic test_alias();
    obs_t o;
    logic [LW-1:0] a, e;
    a = rand_line();
    xact(1'b0, 32'h25, a, 1'b1, o);
    e = model_step(1'b0, 32'h25, a, 1'b1);
    xact(1'b0, 32'h05, '0, 1'b0, o);
    e = model_step(1'b0, 32'h05, '0, 1'b0);
    tot_cnt++; if (o.data !== e) $display("FAIL alias_read: got %h want %h", o.data, e); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int times [3];
    logic [LW-1:0] datas [3];
    int np = 0;
    int extra = 0;
    logic [31:0] addr;
    logic [LW-1:0] e;
    addr = {$urandom_range(0, 255), 27'd0} | 32'($urandom_range(0, 31));
    @(negedge clk);
    drive(1'b0, addr, '0, 1'b0, 1'b1);
    for (int c = 0; c <= 40 && np < 3; c++) begin
      @(posedge clk); #1;
      if (bus4.mem_data_ready) begin
        times[np] = c; datas[np] = bus4.mem_data_data; np++;
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk); #1;
      if (bus4.mem_data_ready) extra++;
    end
    tot_cnt++; if (np !== 3) $display("FAIL b2b_pulses: got %0d want 3", np); else pass_cnt++;
    for (int k = 0; k < np; k++) begin
      e = model_step(1'b0, addr, '0, 1'b0);
      tot_cnt++; if (times[k] !== 4 + 6 * k) $display("FAIL b2b_spacing%0d: got edge %0d want %0d", k, times[k], 4 + 6 * k); else pass_cnt++;
      tot_cnt++; if (datas[k] !== e) $display("FAIL b2b_data%0d: got %h want %h", k, datas[k], e); else pass_cnt++;
    end
    tot_cnt++; if (extra !== 0) $display("FAIL b2b_extra_pulses: got %0d want 0", extra); else pass_cnt++;
    tot_cnt++; if (rdc4 !== m_rd4) $display("FAIL b2b_rd_count: got %0d want %0d", rdc4, m_rd4); else pass_cnt++;
  endtask

  task automatic test_latency1_wrap();
    obs_t o;
    logic [31:0] addr;
    logic [LW-1:0] d, e;
    addr = $urandom;
    d = rand_line();
    xact(1'b1, addr, d, 1'b1, o);
    e = model_step(1'b1, addr, d, 1'b1);
    tot_cnt++; if (o.lat !== 1) $display("FAIL l1_wr_latency: got %0d want 1", o.lat); else pass_cnt++;
    tot_cnt++; if (!o.one_wide || !o.busy_cool || !o.idle_after) $display("FAIL l1_shape: got width=%b cool=%b idle=%b want 1/1/1", o.one_wide, o.busy_cool, o.idle_after); else pass_cnt++;
    xact(1'b1, addr ^ 32'hFFFF_FFE0, '0, 1'b0, o);
    e = model_step(1'b1, addr ^ 32'hFFFF_FFE0, '0, 1'b0);
    tot_cnt++; if (o.lat !== 1) $display("FAIL l1_rd_latency: got %0d want 1", o.lat); else pass_cnt++;
    tot_cnt++; if (o.data !== e) $display("FAIL l1_rd_data: got %h want %h", o.data, e); else pass_cnt++;
    // Preload the read counter just below the wrap point.
    @(negedge clk);
    force dut1.rd_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut1.rd_count_q;
    m_rd1 = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      xact(1'b1, $urandom, '0, 1'b0, o);
      e = model_step(1'b1, 32'h0, '0, 1'b0);
      tot_cnt++; if (rdc1 !== m_rd1) $display("FAIL l1_rd_wrap%0d: got %h want %h", k, rdc1, m_rd1); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [LW-1:0] b, e;
    int lat = -1;
    logic [LW-1:0] got = '0;
    b = rand_line();
    @(negedge clk);
    drive(1'b0, 32'd7, b, 1'b1, 1'b1);
    repeat (3) @(posedge clk);                 // E0, E0+1, E0+2
    #1 HRESETn = 1'b0;
    m_rd4 = 0; m_wr4 = 0; m_rd1 = 0; m_wr1 = 0;
    #1;
    tot_cnt++; if (busy4 !== 1'b0 || bus4.mem_data_ready !== 1'b0) $display("FAIL mid_rst_abort: got busy=%b ready=%b want 0/0", busy4, bus4.mem_data_ready); else pass_cnt++;
    // Request the read while still in reset; it must be taken on the first edge after release.
    @(negedge clk);
    drive(1'b0, 32'h0000_0007, rand_line(), 1'b0, 1'b1);
    @(negedge clk);
    HRESETn = 1'b1;
    tot_cnt++; if (wrc4 !== 16'd0 || rdc1 !== 16'd0) $display("FAIL mid_rst_counts: got wr4=%0d rd1=%0d want 0/0", wrc4, rdc1); else pass_cnt++;
    @(posedge clk); #1;                        // E0
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus4.mem_data_ready) begin lat = n; got = bus4.mem_data_data; end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    e = model_step(1'b0, 32'd7, '0, 1'b0);
    tot_cnt++; if (lat !== 4) $display("FAIL mid_rst_release_latency: got %0d want 4", lat); else pass_cnt++;
    tot_cnt++; if (got !== e) $display("FAIL mid_rst_read: got %h want %h", got, e); else pass_cnt++;
    tot_cnt++; if (wrc4 !== m_wr4 || rdc4 !== m_rd4) $display("FAIL mid_rst_after: got wr=%0d rd=%0d want %0d/%0d", wrc4, rdc4, m_wr4, m_rd4); else pass_cnt++;
  endtask

  task automatic test_random();
    obs_t o;
    logic [31:0] addr;
    logic [LW-1:0] d, e;
    bit rw;
    for (int k = 0; k < 40; k++) begin
      addr = $urandom;
      rw   = 1'($urandom_range(0, 1));
      d    = rand_line();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      xact(1'b0, addr, d, rw, o);
      e = model_step(1'b0, addr, d, rw);
      tot_cnt++; if (o.lat !== 4 || o.data !== e) $display("FAIL rand%0d: got lat=%0d data=%h want lat=4 data=%h", k, o.lat, o.data, e); else pass_cnt++;
    end
    tot_cnt++; if (wrc4 !== m_wr4 || rdc4 !== m_rd4) $display("FAIL rand_counts: got wr=%0d rd=%0d want %0d/%0d", wrc4, rdc4, m_wr4, m_rd4); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem4[i] = '0;
      mem1[i] = '0;
    end
    m_rd4 = 0; m_wr4 = 0; m_rd1 = 0; m_wr1 = 0;
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_latency1_wrap();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, tot_cnt);
    $fatal(1, "timeout");
  end
endmodule
